// File: rtl/prio_pkg.sv
// Shared definitions for the pipelined priority encoder: default geometry and
// the constant log2 helper used to size index ports.
package prio_pkg;

  localparam int N_DEF = 16;
  localparam int G_DEF = 4;

  // Smallest r with 2**r >= v; evaluated at elaboration for port widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_grp.sv
// Combinational priority encoder for one G-bit group; direction chosen by
// msb_first so the group and the global selection always agree.
module prio_enc_grp
  import prio_pkg::*;
#(
  parameter int G = G_DEF
) (
  input  logic [G-1:0]          w,
  input  logic                  msb_first,
  output logic [clog2(G)-1:0]   idx,
  output logic                  any
);

  localparam int LG = clog2(G);

  // The last match in scan order wins, so scan toward the preferred end.
  always_comb begin
    idx = '0;
    any = |w;
    if (msb_first) begin
      for (int i = 0; i < G; i++) begin
        if (w[i]) idx = LG'(i);
      end
    end else begin
      for (int i = G - 1; i >= 0; i--) begin
        if (w[i]) idx = LG'(i);
      end
    end
  end

endmodule

// File: rtl/prio_enc_pipe.sv
// Two-stage priority encoder with valid/ready handshakes: stage 1 encodes each
// group locally, stage 2 picks the winning group and forms the final index.
module prio_enc_pipe
  import prio_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int G = G_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          w,
  input  logic                  msb_first,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [clog2(N)-1:0]   y,
  output logic                  z,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int NG = N / G;
  localparam int LG = clog2(G);
  localparam int GW = clog2(NG);
  localparam int YW = clog2(N);

  if (N < 8 || N > 64 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("prio_enc_pipe: N must be a power of two in 8..64");
  end
  if (G < 2 || G > N / 2 || (G & (G - 1)) != 0 || (N % G) != 0) begin : g_bad_g
    $error("prio_enc_pipe: G must be a power of two in 2..N/2 dividing N");
  end

  logic [LG-1:0] grp_idx [NG];
  logic [NG-1:0] grp_any;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    prio_enc_grp #(.G(G)) u_grp (
      .w         (w[g*G +: G]),
      .msb_first (msb_first),
      .idx       (grp_idx[g]),
      .any       (grp_any[g])
    );
  end

  logic          vld_p1_q, vld_p1_d;
  logic [LG-1:0] idx_p1_q [NG];
  logic [NG-1:0] any_p1_q;
  logic          msb_p1_q;

  logic          vld_p2_q, vld_p2_d;
  logic [YW-1:0] y_q, y_d;
  logic          z_q, z_d;
  logic [GW-1:0] win_grp;

  logic s2_free, ld_p1, ld_p2;

  // in_ready depends only on registered valids and out_ready.
  always_comb begin
    s2_free  = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || s2_free;
    ld_p1    = in_valid && in_ready;
    ld_p2    = vld_p1_q && s2_free;
    vld_p1_d = in_ready ? in_valid : vld_p1_q;
    vld_p2_d = s2_free ? vld_p1_q : vld_p2_q;
  end

  // Stage 1 boundary: per-group local index, any-set flag and direction.
  always_ff @(posedge clk) begin
    if (ld_p1) begin
      idx_p1_q <= grp_idx;
      any_p1_q <= grp_any;
      msb_p1_q <= msb_first;
    end
  end

  always_comb begin
    win_grp = '0;
    if (msb_p1_q) begin
      for (int g = 0; g < NG; g++) begin
        if (any_p1_q[g]) win_grp = GW'(g);
      end
    end else begin
      for (int g = NG - 1; g >= 0; g--) begin
        if (any_p1_q[g]) win_grp = GW'(g);
      end
    end
    z_d = ~|any_p1_q;
    y_d = z_d ? '0 : {win_grp, idx_p1_q[win_grp]};
  end

  // Stage 2 boundary: final index; outputs reset to the all-zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      y_q      <= '0;
      z_q      <= 1'b1;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (ld_p2) begin
        y_q <= y_d;
        z_q <= z_d;
      end
    end
  end

  assign y         = y_q;
  assign z         = z_q;
  assign out_valid = vld_p2_q;

endmodule
